// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path.
//
//   Contents:
//     UART_DEFAULT_CLKS_PER_BIT : default bit period in clk cycles
//                                 (100 MHz clock, 9600 baud)
//     UART_IDLE_LEVEL           : level of the serial line when nothing is sent
//     UART_DATA_BITS            : payload bits per frame
//     UART_BAUD_CNT_W           : width of the bit-period counter (covers 65535)
//     tx_state_e                : transmitter state encoding
//     uart_even_parity()        : even parity over one data byte
//
//   Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and the
//   parity helper. Without it neither exists.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 10417;
  localparam logic        UART_IDLE_LEVEL           = 1'b1;
  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_BAUD_CNT_W           = 16;

  // Explicit encodings keep the values stable whether or not the parity
  // state is compiled in, so debug captures read the same across builds.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even,
  // which is simply the XOR of the data bits.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter. Counts clk cycles while enabled and emits a
//   one-cycle tick on the last cycle of every bit period, then wraps to 0.
//
//   Parameters:
//     CLKS_PER_BIT : clk cycles per serial bit (2..65535)
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous active-low reset, clears the counter
//     clear  : synchronous clear, restarts the bit period from 0
//     enable : count while high; the counter holds while low
//     tick   : high during the final cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [UART_BAUD_CNT_W-1:0] LAST_CNT = UART_BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [UART_BAUD_CNT_W-1:0] cnt;
  logic                       at_last;

  assign at_last = (cnt == LAST_CNT);

  // Tick is decoded from the registered count, so it is glitch-free and
  // lines up with the cycle in which the current bit is still on the line.
  assign tick = enable & at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   8-bit UART transmitter. A rising edge on tx_en while idle latches
//   tx_data and sends one frame: start bit (0), 8 data bits LSB first,
//   optional even parity bit, stop bit (1). Every bit lasts CLKS_PER_BIT
//   clk cycles.
//
//   Parameters:
//     CLKS_PER_BIT : clk cycles per serial bit (2..65535)
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous active-low reset
//     tx_data   : byte to send, sampled only on the accepted tx_en edge
//     tx_en     : transmit request level; only its rising edge matters
//     txd       : serial line, idles high
//     tx_status : 1 = idle and ready, 0 = frame in progress
//     tx_done   : one-cycle pulse in the first idle cycle after a frame
//     state_dbg : current transmitter state, for observation only
//
//   Handshake: tx_en is edge-triggered, not valid/ready. A request is taken
//   only when tx_en was low on the previous clock, is high now, and the
//   transmitter is in IDLE. Edges seen while busy are dropped (no queueing,
//   no abort), and a level held high yields exactly one frame.
//
//   Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
//   between the last data bit and the stop bit (11-bit frame instead of 10).
// ---------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       txd,
  output logic       tx_status,
  output logic       tx_done,
  output tx_state_e  state_dbg
);

  tx_state_e  state;
  logic       tx_en_q;
  logic [7:0] data_q;
  logic [2:0] bit_idx;
  logic [2:0] next_idx;
  logic       start_cond;
  logic       baud_tick;
  logic       busy;

  // tx_en_q resets to 1 so a level that is already high when reset is
  // released does not look like a fresh request.
  assign start_cond = tx_en & ~tx_en_q & (state == TX_IDLE);
  assign busy       = (state != TX_IDLE);
  assign next_idx   = bit_idx + 3'd1;
  assign state_dbg  = state;

  // The counter is cleared on the accepting edge so the start bit gets a
  // full bit period regardless of where the counter was left.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_cond),
    .enable (busy),
    .tick   (baud_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= TX_IDLE;
      txd       <= UART_IDLE_LEVEL;
      tx_status <= 1'b1;
      tx_done   <= 1'b0;
      tx_en_q   <= 1'b1;
      data_q    <= 8'h00;
      bit_idx   <= 3'd0;
    end else begin
      tx_en_q <= tx_en;
      tx_done <= 1'b0;

      case (state)
        TX_IDLE: begin
          if (start_cond) begin
            data_q    <= tx_data;
            bit_idx   <= 3'd0;
            state     <= TX_START;
            txd       <= ~UART_IDLE_LEVEL;
            tx_status <= 1'b0;
          end
        end

        TX_START: begin
          if (baud_tick) begin
            state <= TX_DATA;
            txd   <= data_q[0];
          end
        end

        TX_DATA: begin
          if (baud_tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= TX_PARITY;
              txd   <= uart_even_parity(data_q);
`else
              state <= TX_STOP;
              txd   <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_idx <= next_idx;
              txd     <= data_q[next_idx];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (baud_tick) begin
            state <= TX_STOP;
            txd   <= UART_IDLE_LEVEL;
          end
        end
`endif

        TX_STOP: begin
          // The cycle after the stop bit is already IDLE, so a new request
          // can be accepted on the very edge that ends the tx_done cycle.
          if (baud_tick) begin
            state     <= TX_IDLE;
            tx_status <= 1'b1;
            tx_done   <= 1'b1;
          end
        end

        default: begin
          state     <= TX_IDLE;
          txd       <= UART_IDLE_LEVEL;
          tx_status <= 1'b1;
        end
      endcase
    end
  end

endmodule
